// File: rtl/afifo_wptr_ctrl.sv
// Write-domain pointer and flag controller for the async FIFO: binary/Gray write
// pointer, read-pointer synchronizer, and full / almost-full / level / overflow flags.
module afifo_wptr_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  winc,
  input  logic                  wovf_clr,
  input  logic [ADDR_WIDTH:0]   rptr_gray_async,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  wovf
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [PW-1:0] AFULL_LEVEL = PW'(DEPTH - AFULL_THRESH);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rq_sync;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] level_next;
  logic [PW-1:0] full_cmp;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic          push;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign push       = winc & ~wfull;
  // No write is accepted while reset is held, so the memory must not see one either.
  assign wen        = push & wrst_n;
  assign wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, push};
  assign wgray_next = bin2gray(wbin_next);
  assign rq_sync    = sync_q[SYNC_STAGES-1];
  assign rbin_sync  = gray2bin(rq_sync);
  assign level_next = wbin_next - rbin_sync;
  assign full_cmp   = {~rq_sync[PW-1:PW-2], rq_sync[PW-3:0]};
  assign waddr      = wbin[ADDR_WIDTH-1:0];

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr_gray    <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      wovf         <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rptr_gray_async;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      wbin         <= wbin_next;
      wptr_gray    <= wgray_next;
      wfull        <= (wgray_next == full_cmp);
      walmost_full <= (level_next >= AFULL_LEVEL);
      wlevel       <= level_next;
      // A dropped write on the same edge as a clear keeps the error visible.
      if (winc && wfull)  wovf <= 1'b1;
      else if (wovf_clr)  wovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_afifo_wptr_ctrl.sv
// Scoreboard bench for afifo_wptr_ctrl: directed scenarios plus random traffic,
// checked against an occupancy-arithmetic model of the write side.
module tb_afifo_wptr_ctrl;

  localparam int AW    = 4;
  localparam int PW    = AW + 1;
  localparam int SYNC  = 2;
  localparam int DEPTH = 16;
  localparam int MOD   = 32;

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b0;
  logic          winc = 1'b0;
  logic          wovf_clr = 1'b0;
  logic [PW-1:0] rptr_gray_async = '0;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [PW-1:0] wptr_gray;
  logic          wfull;
  logic          walmost_full;
  logic [PW-1:0] wlevel;
  logic          wovf;

  afifo_wptr_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(2), .SYNC_STAGES(SYNC)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wovf_clr(wovf_clr),
    .rptr_gray_async(rptr_gray_async), .wen(wen), .waddr(waddr),
    .wptr_gray(wptr_gray), .wfull(wfull), .walmost_full(walmost_full),
    .wlevel(wlevel), .wovf(wovf)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic          wen;
    logic [AW-1:0] waddr;
    logic [PW-1:0] gray;
    logic          full;
    logic          afull;
    logic [PW-1:0] level;
    logic          ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Model state: write count, read pointer seen after the synchronizer delay.
  int   m_wbin = 0;
  int   m_level = 0;
  bit   m_full = 0;
  bit   m_afull = 0;
  bit   m_ovf = 0;
  int   hist[$];
  int   rd = 0;

  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) % MOD;
  endfunction

  function automatic int g2b(input int g);
    int b = 0;
    for (int s = 0; s < PW; s++) b = b ^ (g >> s);
    return b % MOD;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
    end
  endtask

  task automatic step(input bit rst_n, input bit winc_i, input bit clr_i, input int rp);
    exp_t e;
    int   rq;
    bit   acc;
    @(negedge wclk);
    wrst_n          = rst_n;
    winc            = winc_i;
    wovf_clr        = clr_i;
    rptr_gray_async = PW'(rp);
    e.wen = rst_n && winc_i && !m_full;
    if (!rst_n) begin
      m_wbin = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0; rd = 0;
      hist = {};
      repeat (SYNC) hist.push_back(0);
    end else begin
      rq = hist.pop_front();
      hist.push_back(rp);
      acc = winc_i && !m_full;
      if (winc_i && m_full) m_ovf = 1;
      else if (clr_i)       m_ovf = 0;
      m_wbin  = (m_wbin + int'(acc)) % MOD;
      m_level = (m_wbin - g2b(rq) + MOD) % MOD;
      m_full  = (m_level == DEPTH);
      m_afull = (m_level >= DEPTH - 2);
    end
    e.waddr = AW'(m_wbin % DEPTH);
    e.gray  = PW'(b2g(m_wbin));
    e.full  = m_full;
    e.afull = m_afull;
    e.level = PW'(m_level);
    e.ovf   = m_ovf;
    exp_q.push_back(e);
  endtask

  // Monitor: wen is checked mid-cycle against the pending entry, registered
  // outputs just after the edge that retires it.
  initial begin
    exp_t e;
    forever begin
      @(negedge wclk);
      #2;
      if (exp_q.size() == 0) continue;
      e = exp_q[0];
      chk("wen", 32'(wen), 32'(e.wen));
      @(posedge wclk);
      #1;
      e = exp_q.pop_front();
      chk("waddr", 32'(waddr), 32'(e.waddr));
      chk("wptr_gray", 32'(wptr_gray), 32'(e.gray));
      chk("wfull", 32'(wfull), 32'(e.full));
      chk("walmost_full", 32'(walmost_full), 32'(e.afull));
      chk("wlevel", 32'(wlevel), 32'(e.level));
      chk("wovf", 32'(wovf), 32'(e.ovf));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rp;
    repeat (SYNC) hist.push_back(0);

    repeat (3)  step(0, 1, 0, 0);
    repeat (2)  step(1, 0, 0, 0);
    repeat (16) step(1, 1, 0, 0);
    repeat (2)  step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    step(1, 0, 1, 0);
    repeat (4)  step(1, 0, 0, b2g(1));
    step(1, 1, 0, b2g(1));
    repeat (2)  step(1, 0, 0, b2g(1));

    step(0, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      rp = (i < 4) ? 0 : b2g((m_wbin + MOD - 4) % MOD);
      step(1, 1, 0, rp);
    end

    step(0, 0, 0, 0);
    repeat (9) step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      if ((((m_wbin - rd + MOD) % MOD) > 0) && ($urandom_range(0, 99) < 45))
        rd = (rd + 1) % MOD;
      step($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 60,
           $urandom_range(0, 9) == 0, b2g(rd));
    end

    repeat (3) @(negedge wclk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
